// File: rtl/passive_alarm_ctrl.sv
// Passive-alarm chime controller.
// Debounces the passive-security condition, then pulses the chime for a
// bounded number of beeps. Driver acknowledge or beep-count timeout silence
// it; re-arming needs the condition to drop and be debounced again.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | armed, waiting for passive_signal
//   S_DEBOUNCE | counting consecutive high samples of passive_signal
//   S_BEEP_ON  | chime driven high, phase timer running
//   S_BEEP_OFF | chime low between beeps, phase timer running
//   S_SILENCED | acknowledged or timed out; waits for the condition to drop
module passive_alarm_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int BEEP_ON_CYCLES  = 3,
    parameter int BEEP_OFF_CYCLES = 2,
    parameter int MAX_BEEPS       = 5,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             passive_signal,
    input  logic             ack,
    output logic             chime,
    output logic             alarm_active,
    output logic             timeout_flag,
    output logic [CNT_W-1:0] beep_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_BEEP_ON  = 3'd2,
        S_BEEP_OFF = 3'd3,
        S_SILENCED = 3'd4
    } state_t;

    // Phase timer is a down-counter loaded with (length - 1); the phase ends
    // on the edge where it reads zero.
    localparam logic [CNT_W-1:0] C_ZERO     = '0;
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ON_LOAD  = CNT_W'(BEEP_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_OFF_LOAD = CNT_W'(BEEP_OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_BEEPS);

    state_t           r_state;
    logic [CNT_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_tmr;
    logic [CNT_W-1:0] r_beep_cnt;
    logic             r_tof;
    logic             r_chime;
    logic             r_alarm;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_deb_nxt;
    logic [CNT_W-1:0] w_tmr_nxt;
    logic [CNT_W-1:0] w_beep_nxt;
    logic             w_tof_nxt;
    logic             w_chime_nxt;
    logic             w_alarm_nxt;
    logic [CNT_W-1:0] w_beep_inc;

    // Beep counter saturates at MAX_BEEPS.
    assign w_beep_inc = (r_beep_cnt == C_MAX) ? r_beep_cnt : r_beep_cnt + C_ONE;

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_deb_cnt  <= '0;
            r_tmr      <= '0;
            r_beep_cnt <= '0;
            r_tof      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_tmr      <= w_tmr_nxt;
            r_beep_cnt <= w_beep_nxt;
            r_tof      <= w_tof_nxt;
        end
    end

    // Next-state and counter update; priority enable > passive drop > ack > timers.
    always_comb begin
        w_state_nxt = r_state;
        w_deb_nxt   = r_deb_cnt;
        w_tmr_nxt   = r_tmr;
        w_beep_nxt  = r_beep_cnt;
        w_tof_nxt   = r_tof;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_deb_nxt   = '0;
            w_tmr_nxt   = '0;
            w_beep_nxt  = '0;
            w_tof_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_deb_nxt  = '0;
                    w_tmr_nxt  = '0;
                    w_beep_nxt = '0;
                    w_tof_nxt  = 1'b0;
                    if (passive_signal) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            w_state_nxt = S_BEEP_ON;
                            w_tmr_nxt   = C_ON_LOAD;
                            w_beep_nxt  = C_ONE;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                            w_deb_nxt   = C_ONE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (!passive_signal) begin
                        w_state_nxt = S_IDLE;
                        w_deb_nxt   = '0;
                        w_tmr_nxt   = '0;
                        w_beep_nxt  = '0;
                        w_tof_nxt   = 1'b0;
                    end else if (r_deb_cnt >= C_DEB_LAST) begin
                        w_state_nxt = S_BEEP_ON;
                        w_deb_nxt   = '0;
                        w_tmr_nxt   = C_ON_LOAD;
                        w_beep_nxt  = C_ONE;
                    end else begin
                        w_deb_nxt = r_deb_cnt + C_ONE;
                    end
                end
                S_BEEP_ON: begin
                    if (!passive_signal) begin
                        w_state_nxt = S_IDLE;
                        w_tmr_nxt   = '0;
                        w_beep_nxt  = '0;
                        w_tof_nxt   = 1'b0;
                    end else if (ack) begin
                        w_state_nxt = S_SILENCED;
                        w_tmr_nxt   = '0;
                        w_tof_nxt   = 1'b0;
                    end else if (r_tmr == C_ZERO) begin
                        w_state_nxt = S_BEEP_OFF;
                        w_tmr_nxt   = C_OFF_LOAD;
                    end else begin
                        w_tmr_nxt = r_tmr - C_ONE;
                    end
                end
                S_BEEP_OFF: begin
                    if (!passive_signal) begin
                        w_state_nxt = S_IDLE;
                        w_tmr_nxt   = '0;
                        w_beep_nxt  = '0;
                        w_tof_nxt   = 1'b0;
                    end else if (ack) begin
                        w_state_nxt = S_SILENCED;
                        w_tmr_nxt   = '0;
                        w_tof_nxt   = 1'b0;
                    end else if (r_tmr == C_ZERO) begin
                        if (r_beep_cnt >= C_MAX) begin
                            w_state_nxt = S_SILENCED;
                            w_tmr_nxt   = '0;
                            w_tof_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_BEEP_ON;
                            w_tmr_nxt   = C_ON_LOAD;
                            w_beep_nxt  = w_beep_inc;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr - C_ONE;
                    end
                end
                S_SILENCED: begin
                    // A held condition never re-triggers; only a drop re-arms.
                    if (!passive_signal) begin
                        w_state_nxt = S_IDLE;
                        w_deb_nxt   = '0;
                        w_tmr_nxt   = '0;
                        w_beep_nxt  = '0;
                        w_tof_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_deb_nxt   = '0;
                    w_tmr_nxt   = '0;
                    w_beep_nxt  = '0;
                    w_tof_nxt   = 1'b0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        w_chime_nxt = (w_state_nxt == S_BEEP_ON);
        w_alarm_nxt = (w_state_nxt == S_BEEP_ON) || (w_state_nxt == S_BEEP_OFF);
    end

    // Registered chime and alarm outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chime <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_chime <= w_chime_nxt;
            r_alarm <= w_alarm_nxt;
        end
    end

    assign chime        = r_chime;
    assign alarm_active = r_alarm;
    assign timeout_flag = r_tof;
    assign beep_count   = r_beep_cnt;

endmodule

// File: tb/tb_passive_alarm_ctrl.sv
// Scoreboard bench for passive_alarm_ctrl at default parameters.
// Expected vector layout: {chime, alarm_active, timeout_flag, beep_count[7:0]}.
module tb_passive_alarm_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       passive_signal;
    logic       ack;
    logic       chime;
    logic       alarm_active;
    logic       timeout_flag;
    logic [7:0] beep_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       nm;
        logic [10:0] ex;
    } sb_t;

    sb_t sb[$];

    passive_alarm_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .passive_signal (passive_signal),
        .ack            (ack),
        .chime          (chime),
        .alarm_active   (alarm_active),
        .timeout_flag   (timeout_flag),
        .beep_count     (beep_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] ex);
        n_checks++;
        if (act !== ex) begin
            n_errors++;
            $display("FAIL %s: got chime=%b alarm=%b tof=%b cnt=%0d, expected chime=%b alarm=%b tof=%b cnt=%0d",
                     nm, act[10], act[9], act[8], act[7:0], ex[10], ex[9], ex[8], ex[7:0]);
        end
    endtask

    // Uninterrupted episode at defaults, k = edges since first high sample:
    // 3 debounce edges silent, then 5 beeps of (3 on + 2 off), then timed out.
    function automatic logic [10:0] exp_ep(input int k);
        int         j;
        logic [7:0] c;
        if (k < 3) return 11'd0;
        j = k - 3;
        if (j >= 25) return {1'b0, 1'b0, 1'b1, 8'd5};
        c = 8'(j / 5 + 1);
        return {((j % 5) < 3), 1'b1, 1'b0, c};
    endfunction

    task automatic step(input logic en, input logic ps, input logic ak,
                        input logic [10:0] ex, input string nm);
        @(negedge clk);
        enable         = en;
        passive_signal = ps;
        ack            = ak;
        sb.push_back('{nm, ex});
    endtask

    task automatic ep(input int k, input logic ak, input string nm);
        step(1'b1, 1'b1, ak, exp_ep(k), $sformatf("%s_k%0d", nm, k));
    endtask

    task automatic ep_run(input int k0, input int k1, input string nm);
        for (int k = k0; k <= k1; k++) ep(k, 1'b0, nm);
    endtask

    task automatic idle_step(input string nm);
        step(1'b1, 1'b0, 1'b0, 11'd0, nm);
    endtask

    // Monitor: one registered output vector per clock edge.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.nm, {chime, alarm_active, timeout_flag, beep_count}, e.ex);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        passive_signal = 1'b0;
        ack            = 1'b0;
        #3;
        chk("reset_state", {chime, alarm_active, timeout_flag, beep_count}, 11'd0);
        #9 reset = 1'b0;

        // 1: reset during the second BEEP_ON
        idle_step("t1_idle");
        ep_run(0, 8, "t1");
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("t1_async_reset", {chime, alarm_active, timeout_flag, beep_count}, 11'd0);
        #2 reset = 1'b0;
        idle_step("t1_after_reset");
        ep_run(0, 3, "t1_rearm");
        idle_step("t1_drop");

        // 2: glitch rejection, then a fresh debounce
        ep_run(0, 2, "t2_glitch");
        idle_step("t2_low");
        ep_run(0, 4, "t2_fresh");
        idle_step("t2_drop");

        // 3: full timeout episode, held past the end, then drop
        ep_run(0, 31, "t3");
        idle_step("t3_drop");

        // 4: ack on the second beep, then condition held for 40 cycles
        ep_run(0, 8, "t4");
        step(1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 8'd2}, "t4_ack");
        for (int i = 0; i < 40; i++)
            step(1'b1, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 8'd2}, "t4_held");
        idle_step("t4_drop");

        // 5: drop during the third BEEP_OFF, then re-assert
        ep_run(0, 16, "t5");
        idle_step("t5_drop");
        ep_run(0, 4, "t5_rearm");
        idle_step("t5_drop2");

        // ack is ignored during debounce
        ep(0, 1'b0, "dack");
        ep(1, 1'b1, "dack");
        ep(2, 1'b1, "dack");
        ep(3, 1'b0, "dack");
        idle_step("dack_drop");

        // ack together with passive drop goes to IDLE
        ep_run(0, 4, "ackdrop");
        step(1'b1, 1'b0, 1'b1, 11'd0, "ackdrop_idle");

        // 6a: enable low with ack during BEEP_ON -> IDLE, proven by fresh debounce
        ep_run(0, 3, "t6a");
        step(1'b0, 1'b1, 1'b1, 11'd0, "t6a_disable");
        ep_run(0, 3, "t6a_rearm");
        idle_step("t6a_drop");

        // 6b: ack on the final BEEP_OFF expiry edge wins over timeout
        ep_run(0, 27, "t6b");
        step(1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 8'd5}, "t6b_ack_final");
        step(1'b1, 1'b1, 1'b0, {1'b0, 1'b0, 1'b0, 8'd5}, "t6b_held");
        idle_step("t6b_drop");

        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
